// File: rtl/score_display_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : score_display_pkg
// Brief  : Segment patterns, FSM states and BCD helper for score_display.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package score_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  // Active-low {G,F,E,D,C,B,A}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] C_MAX_SCORE = 7'd99;
  localparam logic [2:0] C_LAST_STEP = 3'd6;
  localparam logic [3:0] C_NO_DIGIT  = 4'hF;

  function automatic logic [3:0] bcd_adjust(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_display_seven_seg_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : seven_seg_encoder
// Brief  : BCD digit to active-low 7-segment pattern; codes 10..15 blank.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module seven_seg_encoder
  import score_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/score_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : score_display
// Brief  : Binary score (0..99) to two blinkable 7-segment digits via
//          iterative shift-add-3 conversion.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module score_display
  import score_display_pkg::*;
#(
  parameter int BLINK_CYCLES       = 12_500_000,
  parameter bit LEADING_ZERO_BLANK = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [6:0] value,
  input  logic       load,
  input  logic       blink_enable,
  output logic       busy,
  output logic       done,
  output logic       overflow,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones
);

  localparam int C_CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(BLINK_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [6:0]         r_bin;
  logic [7:0]         r_bcd;
  logic [7:0]         w_bcd_adj;
  logic [2:0]         r_bit_cnt;
  logic [3:0]         r_tens;
  logic [3:0]         r_ones;
  logic               r_done;
  logic               r_overflow;
  logic [6:0]         r_seg_tens;
  logic [6:0]         r_seg_ones;
  logic [C_CNT_W-1:0] r_blink_cnt;
  logic               r_phase_on;
  logic               w_cnt_wrap;
  logic               w_phase_on_next;
  logic [3:0]         w_tens_src;
  logic [3:0]         w_ones_src;
  logic [6:0]         w_tens_pat;
  logic [6:0]         w_ones_pat;
  logic [6:0]         w_tens_shown;
  logic               w_accept;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy     = 1'b0;
        w_accept = load;
        if (load) w_state_next = ST_SHIFT;
      end
      ST_SHIFT:  if (r_bit_cnt == C_LAST_STEP) w_state_next = ST_UPDATE;
      ST_UPDATE: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  assign w_bcd_adj = {bcd_adjust(r_bcd[7:4]), bcd_adjust(r_bcd[3:0])};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_bit_cnt  <= '0;
      r_tens     <= C_NO_DIGIT;
      r_ones     <= C_NO_DIGIT;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= (r_state == ST_UPDATE);
      if (w_accept) begin
        r_bin      <= (value > C_MAX_SCORE) ? C_MAX_SCORE : value;
        r_bcd      <= '0;
        r_bit_cnt  <= '0;
        r_overflow <= (value > C_MAX_SCORE);
      end else if (r_state == ST_SHIFT) begin
        {r_bcd, r_bin} <= {w_bcd_adj[6:0], r_bin, 1'b0};
        r_bit_cnt      <= r_bit_cnt + 3'd1;
      end else if (r_state == ST_UPDATE) begin
        r_tens <= r_bcd[7:4];
        r_ones <= r_bcd[3:0];
      end
    end
  end

  // Phase for the cycle the output registers are about to present, so the
  // display follows blink_enable without an extra cycle of lag.
  assign w_cnt_wrap      = (r_blink_cnt == C_CNT_MAX);
  assign w_phase_on_next = !blink_enable ? 1'b1 : (w_cnt_wrap ? ~r_phase_on : r_phase_on);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt <= '0;
      r_phase_on  <= 1'b1;
    end else begin
      r_phase_on <= w_phase_on_next;
      if (!blink_enable || w_cnt_wrap) r_blink_cnt <= '0;
      else                             r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // Bypass the digit registers in UPDATE so segments land with done.
  assign w_tens_src = (r_state == ST_UPDATE) ? r_bcd[7:4] : r_tens;
  assign w_ones_src = (r_state == ST_UPDATE) ? r_bcd[3:0] : r_ones;

  seven_seg_encoder u_enc_tens (
    .bcd (w_tens_src),
    .seg (w_tens_pat)
  );

  seven_seg_encoder u_enc_ones (
    .bcd (w_ones_src),
    .seg (w_ones_pat)
  );

  assign w_tens_shown = (LEADING_ZERO_BLANK && (w_tens_src == 4'd0)) ? SEG_BLANK : w_tens_pat;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_seg_tens <= SEG_BLANK;
      r_seg_ones <= SEG_BLANK;
    end else begin
      r_seg_tens <= w_phase_on_next ? w_tens_shown : SEG_BLANK;
      r_seg_ones <= w_phase_on_next ? w_ones_pat   : SEG_BLANK;
    end
  end

  assign done     = r_done;
  assign overflow = r_overflow;
  assign seg_tens = r_seg_tens;
  assign seg_ones = r_seg_ones;

endmodule
`default_nettype wire
